// File: rtl/speed_pkg.sv
// Shared state encoding, default timing constants and counter sizing
// for the speed-round controller.
package speed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_ROUND     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CLEAR     = 3'd4
    } state_e;

    localparam int unsigned DEF_TICK_DIV        = 10_000_000;
    localparam int unsigned DEF_COUNTDOWN_TICKS = 3;
    localparam int unsigned DEF_ROUND_TICKS     = 5;

    localparam int unsigned COUNTDOWN_W = 4;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/speed_round_ctrl_if.sv
// Request, push-counter flag and status signals of the speed-round controller.
interface speed_round_ctrl_if;
    import speed_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   speed_tie;
    logic                   speed_right;
    logic                   speedRound;
    logic                   speedExit;
    logic [COUNTDOWN_W-1:0] countdown;
    logic                   busy;
    logic                   result_valid;
    logic                   winner_right;
    logic                   winner_tie;

    modport master (
        output start,
        output abort,
        output speed_tie,
        output speed_right,
        input  speedRound,
        input  speedExit,
        input  countdown,
        input  busy,
        input  result_valid,
        input  winner_right,
        input  winner_tie
    );

    modport slave (
        input  start,
        input  abort,
        input  speed_tie,
        input  speed_right,
        output speedRound,
        output speedExit,
        output countdown,
        output busy,
        output result_valid,
        output winner_right,
        output winner_tie
    );

endinterface

// File: rtl/speed_round_ctrl_tick_gen.sv
// Game-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// so each phase begins on a full tick period.
module tick_gen
    import speed_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned         CNT_W    = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/speed_round_ctrl.sv
// Speed-round sequencer: countdown, timed push-counting window, settle,
// winner latch and push-counter clear pulse.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | waiting for start; last result held
//   COUNTDOWN | pre-round countdown, one step per tick
//   ROUND     | speedRound high, pushes being counted
//   SETTLE    | 2 cycles for push-counter flags to catch up
//   CLEAR     | speedExit pulse clears push-counter counts
module speed_round_ctrl
    import speed_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned COUNTDOWN_TICKS = DEF_COUNTDOWN_TICKS,
    parameter int unsigned ROUND_TICKS     = DEF_ROUND_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    speed_round_ctrl_if.slave bus
);

    localparam int unsigned               RND_W   = cnt_width(ROUND_TICKS - 1);
    localparam logic [RND_W-1:0]          RND_LOAD = RND_W'(ROUND_TICKS - 1);
    localparam logic [COUNTDOWN_W-1:0]    CD_LOAD  = COUNTDOWN_W'(COUNTDOWN_TICKS);

    state_e                 state_q, state_d;
    logic [COUNTDOWN_W-1:0] countdown_q, countdown_d;
    logic [RND_W-1:0]       rnd_q, rnd_d;
    logic                   settle_q, settle_d;
    logic                   aborted_q, aborted_d;
    logic                   speed_round_q, speed_round_d;
    logic                   speed_exit_q, speed_exit_d;
    logic                   busy_q, busy_d;
    logic                   result_valid_q, result_valid_d;
    logic                   winner_right_q, winner_right_d;
    logic                   winner_tie_q, winner_tie_d;

    logic tick;
    logic tick_restart;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (tick_restart),
        .tick    (tick)
    );

    always_comb begin
        state_d        = state_q;
        countdown_d    = countdown_q;
        rnd_d          = rnd_q;
        settle_d       = settle_q;
        aborted_d      = aborted_q;
        result_valid_d = result_valid_q;
        winner_right_d = winner_right_q;
        winner_tie_d   = winner_tie_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d        = ST_COUNTDOWN;
                    countdown_d    = CD_LOAD;
                    result_valid_d = 1'b0;
                    aborted_d      = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                // abort is checked first so it beats a coincident tick
                if (bus.abort) begin
                    state_d     = ST_CLEAR;
                    countdown_d = '0;
                    aborted_d   = 1'b1;
                end else if (tick) begin
                    if (countdown_q == COUNTDOWN_W'(1)) begin
                        state_d     = ST_ROUND;
                        countdown_d = '0;
                        rnd_d       = RND_LOAD;
                    end else begin
                        countdown_d = countdown_q - 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                if (bus.abort) begin
                    state_d   = ST_CLEAR;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    if (rnd_q == '0) begin
                        state_d  = ST_SETTLE;
                        settle_d = 1'b0;
                    end else begin
                        rnd_d = rnd_q - 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d   = ST_CLEAR;
                    aborted_d = 1'b1;
                end else if (settle_q) begin
                    state_d        = ST_CLEAR;
                    winner_right_d = bus.speed_right;
                    winner_tie_d   = bus.speed_tie;
                end else begin
                    settle_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                if (!aborted_q) begin
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        speed_round_d = (state_d == ST_ROUND);
        speed_exit_d  = (state_d == ST_CLEAR);
        busy_d        = (state_d != ST_IDLE);
        tick_restart  = (state_d != state_q) &&
                        ((state_d == ST_COUNTDOWN) || (state_d == ST_ROUND));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            countdown_q    <= '0;
            rnd_q          <= '0;
            settle_q       <= 1'b0;
            aborted_q      <= 1'b0;
            speed_round_q  <= 1'b0;
            speed_exit_q   <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            winner_right_q <= 1'b0;
            winner_tie_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            countdown_q    <= countdown_d;
            rnd_q          <= rnd_d;
            settle_q       <= settle_d;
            aborted_q      <= aborted_d;
            speed_round_q  <= speed_round_d;
            speed_exit_q   <= speed_exit_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            winner_right_q <= winner_right_d;
            winner_tie_q   <= winner_tie_d;
        end
    end

    assign bus.speedRound   = speed_round_q;
    assign bus.speedExit    = speed_exit_q;
    assign bus.countdown    = countdown_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.winner_right = winner_right_q;
    assign bus.winner_tie   = winner_tie_q;

endmodule

// File: doc/speed_round_ctrl.md
SPEED_ROUND_CTRL -- requirements
Module: speed_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clock cycles per game tick (>=2).
REQ-002 Parameter COUNTDOWN_TICKS, default 3, ticks of pre-round countdown (1..15).
REQ-003 Parameter ROUND_TICKS, default 5, ticks the speed round lasts (>=1).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  synchronous single-cycle request to run one speed round.
REQ-007 abort  input  1  synchronous request to cancel a round in progress.
REQ-008 speed_tie  input  1  push counter "counts equal" flag.
REQ-009 speed_right  input  1  push counter "right count greater" flag.
REQ-010 speedRound  output  1  enables push counting; high only during ROUND.
REQ-011 speedExit  output  1  one-cycle pulse clearing push counter counts.
REQ-012 countdown  output  4  remaining countdown ticks; 0 outside COUNTDOWN.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 result_valid  output  1  winner fields valid; held until next accepted start.
REQ-015 winner_right  output  1  latched right wins.
REQ-016 winner_tie  output  1  latched tie; right=0 and tie=0 means left wins.

Function
REQ-017 FSM states IDLE, COUNTDOWN, ROUND, SETTLE, CLEAR; all outputs registered.
REQ-018 IDLE: start=1 -> COUNTDOWN next cycle, result_valid cleared same edge; start ignored in all other states.
REQ-019 Tick counter restarts at 0 on entry to COUNTDOWN and ROUND; tick asserted when counter reaches TICK_DIV-1, then wraps to 0.
REQ-020 COUNTDOWN: countdown loads COUNTDOWN_TICKS on entry, decrements per tick; tick while countdown==1 -> ROUND, countdown=0.
REQ-021 ROUND: speedRound=1 for exactly ROUND_TICKS*TICK_DIV cycles, then SETTLE.
REQ-022 SETTLE: exactly 2 cycles with speedRound=0, covering the push counter's pulse-to-flag pipeline; on leaving, latch winner_right=speed_right, winner_tie=speed_tie.
REQ-023 CLEAR: speedExit=1 for exactly 1 cycle, then IDLE with result_valid=1.
REQ-024 abort=1 in COUNTDOWN, ROUND or SETTLE -> CLEAR next cycle, no winner latch, result_valid stays 0; abort in IDLE or CLEAR ignored.
REQ-025 abort and start in same IDLE cycle: start wins; abort and tick in same cycle: abort wins.
REQ-026 speedRound and speedExit never high in the same cycle.
REQ-027 Tick and round counters sized for parameter range; no wrap inside a round.

Reset
REQ-028 rst asserted: state IDLE, counters 0, speedRound=0, speedExit=0, countdown=0, busy=0, result_valid=0, winner_right=0, winner_tie=0, asynchronously.
REQ-029 rst mid-round drops speedRound immediately; no speedExit is issued (push counter shares rst).
REQ-030 First start honoured on first rising edge after rst deasserts.

Structure
REQ-031 Package speed_pkg holds state encoding and default TICK_DIV/COUNTDOWN_TICKS/ROUND_TICKS constants.
REQ-032 One sub-module tick_gen (prescaler with synchronous restart input, tick output); FSM and latches in speed_round_ctrl.

Verification (TICK_DIV=4, COUNTDOWN_TICKS=3, ROUND_TICKS=5)
REQ-033 start at cycle 0 -> countdown 3,2,1 for 4 cycles each from cycle 1; speedRound high cycles 13..32; speedExit cycle 35 only; result_valid from cycle 36.
REQ-034 speed_right=1, speed_tie=0 held through SETTLE -> winner_right=1, winner_tie=0; speed_tie=1 -> winner_tie=1, winner_right=0.
REQ-035 abort at cycle 20 (ROUND) -> speedRound=0 cycle 21, speedExit=1 cycle 21, IDLE cycle 22, result_valid=0.
REQ-036 start pulses at cycles 5 and 15 during a round -> timing identical to REQ-033; no restart.
REQ-037 rst at cycle 18 -> all outputs reset values same cycle; start after release produces full REQ-033 sequence.
REQ-038 Second start after result_valid=1 -> result_valid=0 on next cycle, winner fields hold until re-latched.
